sfft_readout_bridge: RTL and testbench
======================================

Name: sfft_readout_bridge

Overview:
- Parametrised memory-mapped readout bridge between the SFFT output buffer and the host's byte-wide bus interface.
- Adds a frame-lock handshake: the host requests a lock, the bridge grants it at a safe frame boundary and holds the pipeline's output buffer stable.
- Snapshots a free-running frame counter at lock time and counts frames missed while locked.
- Replaces ad-hoc combinational readout with a fixed-latency, width/depth-generic read path.

Parameters:
- NUM_WORDS, 256: output-buffer words; power of two.
- WORD_BYTES, 4: bytes per buffer word, 1..4.
- ADDR_WIDTH, 16: host byte-address width; must cover NUM_WORDS*WORD_BYTES+6.
- COUNT_WIDTH, 32: frame counter width, 8..32; zero-extended to 4 bytes on readout.
- BUF_AW, clog2(NUM_WORDS): buffer address width (derived, not overridable).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- chipselect, in, 1: host access strobe.
- write, in, 1: host write qualifier.
- read, in, 1: host read qualifier.
- address, in, ADDR_WIDTH: host byte address.
- writedata, in, 8: host write byte.
- readdata, out, 8: host read byte, registered.
- frame_done, in, 1: one-cycle pulse from the pipeline when a frame has been fully written to the buffer.
- buf_lock, out, 1: high means the pipeline must not overwrite the output buffer.
- buf_addr, out, BUF_AW: buffer word address.
- buf_data, in, 8*WORD_BYTES: buffer word, valid one cycle after buf_addr (synchronous BRAM).

Behaviour:
- Reset values: readdata=0, buf_lock=0, buf_addr=0, FSM=UNLOCKED, frame_cnt=0, snap_cnt=0, ovr_cnt=0, ovr_sticky=0, frame_seen=0.
- Byte address map, with S = NUM_WORDS*WORD_BYTES:
  - [0, S): buffer. Word = addr/WORD_BYTES; lane = addr%WORD_BYTES; lane 0 = bits [7:0] (little-endian).
  - S..S+3: snap_cnt bytes 0..3, little-endian.
  - S+4: status = {5'b0, ovr_sticky, lock_active, valid}.
  - S+5: ovr_cnt.
  - Above S+5: reads return 0x00.
- Read latency is exactly 2 cycles:
  - Cycle 0: chipselect&read; buf_addr is driven combinationally from the address word field; lane and region are registered.
  - Cycle 1: buf_data is valid; the selected byte is registered into readdata.
  - Cycle 2: readdata is visible to the host.
  - Back-to-back reads are pipelined, one per cycle.
  - readdata holds its value when no read is issued.
- Writes take effect only at address S+4 with chipselect&write:
  - bit0 = lock request level.
  - bit1 = clear overrun: zeroes ovr_cnt and ovr_sticky; self-clearing, not stored.
  - Writes to any other address are ignored.
- frame_cnt increments on every frame_done pulse regardless of state and wraps modulo 2^COUNT_WIDTH. frame_done also sets frame_seen.
- FSM states and transitions:
  - UNLOCKED: buf_lock=0. Lock request → PENDING.
  - PENDING: buf_lock=0. The lock is granted, entering LOCKED, on the first cycle where frame_seen=1 and frame_done=0. If frame_done=1 that cycle, grant on the next cycle so the freshest frame is captured. Request dropped → UNLOCKED.
  - LOCKED: buf_lock=1 (registered; asserted the cycle after entry). snap_cnt is loaded with frame_cnt on the entry edge. Each frame_done while LOCKED increments ovr_cnt (saturates at 255) and sets ovr_sticky. Request=0 → UNLOCKED; buf_lock drops the following cycle.
- lock_active = (state==LOCKED). valid = LOCKED & frame_seen.
- A clear-overrun write coinciding with frame_done in LOCKED: the clear wins, so ovr_cnt=0.
- A lock request written while already LOCKED has no effect; snap_cnt is not reloaded.
- Reset asserted mid-lock: buf_lock drops immediately (asynchronously) and all state is cleared; frame_seen=0, so a new lock waits for a fresh frame.

Test Plan:
- Reset, then read S+4 → 0x00. Read S+5 → 0x00. buf_lock=0. Write 0x01 with no frame_done for 100 cycles → buf_lock stays 0 and status=0x00 (PENDING).
- Pulse frame_done 3 times, write 0x01 → buf_lock=1 within 2 cycles. Read S..S+3 → 03 00 00 00. Status → 0x03.
- While locked, pulse frame_done 300 times → ovr_cnt=0xFF and status=0x07. Write 0x03 → ovr_cnt=0x00, status=0x03, lock still held.
- Preload buffer word 5 = 0xA1B2C3D4 (WORD_BYTES=4). Issue back-to-back reads at addresses 20..23 → readdata A1-side reversed sequence D4, C3, B2, A1, each 2 cycles after its request. Read S+6 → 0x00.
- frame_done coincident with the lock request's grant cycle → snap_cnt equals the count including that frame. Write 0x00 → buf_lock=0 on the next cycle.
- Assert reset asynchronously while LOCKED → buf_lock=0 before the next clk edge. All status registers read 0 after reset.

Source files
------------

// File: rtl/sfft_readout_bridge.sv
// Host byte-bus readout of the SFFT output buffer, with frame-lock handshake and frame/overrun counters.
// Latency: readdata is valid exactly 2 cycles after chipselect&read; back-to-back reads pipeline one per cycle.
// Backpressure: none toward the host; buf_lock holds the pipeline off the output buffer while locked.
module sfft_readout_bridge #(
    parameter int NUM_WORDS   = 256,
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32,
    localparam int BUF_AW     = $clog2(NUM_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic                    read,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [7:0]              writedata,
    output logic [7:0]              readdata,
    input  logic                    frame_done,
    output logic                    buf_lock,
    output logic [BUF_AW-1:0]       buf_addr,
    input  logic [8*WORD_BYTES-1:0] buf_data
);

    localparam logic [ADDR_WIDTH-1:0] SBASE     = ADDR_WIDTH'(NUM_WORDS * WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = SBASE + ADDR_WIDTH'(4);

    typedef enum logic [1:0] {UNLOCKED, PENDING, LOCKED} state_t;
    typedef enum logic [1:0] {SRC_BUF, SRC_REG, SRC_ZERO} src_t;

    state_t                 state, state_nxt;
    logic                   lock_req;
    logic [COUNT_WIDTH-1:0] frame_cnt, snap_cnt;
    logic [7:0]             ovr_cnt;
    logic                   ovr_sticky, frame_seen;

    logic       rd_en, wr_stat, req, clr, in_buf, in_reg;
    logic       rd_q;
    src_t       src_q;
    logic [1:0] lane_q;
    logic [2:0] off_q;
    logic [7:0] status, rd_byte;
    logic [31:0] word_ext, snap_ext;

    assign rd_en   = chipselect & read;
    assign wr_stat = chipselect & write & (address == STAT_ADDR);
    // The written level takes effect in the same cycle so the FSM does not lose a cycle on the request.
    assign req     = wr_stat ? writedata[0] : lock_req;
    assign clr     = wr_stat & writedata[1];

    assign in_buf  = address < SBASE;
    assign in_reg  = !in_buf && ((address - SBASE) < ADDR_WIDTH'(6));
    // BRAM address comes straight from the host word field so data lands one cycle later.
    assign buf_addr = (rd_en && in_buf) ? BUF_AW'(address / ADDR_WIDTH'(WORD_BYTES)) : '0;

    assign word_ext = 32'(buf_data);
    assign snap_ext = 32'(snap_cnt);
    assign status   = {5'b0, ovr_sticky, state == LOCKED, (state == LOCKED) & frame_seen};

    // Read stage 0: remember which region/lane the request targets until buf_data arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q   <= 1'b0;
            src_q  <= SRC_ZERO;
            lane_q <= 2'd0;
            off_q  <= 3'd0;
        end else begin
            rd_q <= rd_en;
            if (rd_en) begin
                src_q  <= in_buf ? SRC_BUF : (in_reg ? SRC_REG : SRC_ZERO);
                lane_q <= 2'(address % ADDR_WIDTH'(WORD_BYTES));
                off_q  <= 3'(address - SBASE);
            end
        end
    end

    // Read stage 1: pick the requested byte from the buffer word or the register file.
    always_comb begin
        rd_byte = 8'h00;
        case (src_q)
            SRC_BUF: rd_byte = word_ext[{lane_q, 3'b000} +: 8];
            SRC_REG: begin
                case (off_q)
                    3'd0, 3'd1, 3'd2, 3'd3: rd_byte = snap_ext[{off_q[1:0], 3'b000} +: 8];
                    3'd4:                   rd_byte = status;
                    3'd5:                   rd_byte = ovr_cnt;
                    default:                rd_byte = 8'h00;
                endcase
            end
            default: rd_byte = 8'h00;
        endcase
    end

    // Output register: updated only for issued reads, otherwise holds the last byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     readdata <= 8'h00;
        else if (rd_q) readdata <= rd_byte;
    end

    // Lock FSM next state: grant only on a quiet cycle after a frame, so the freshest frame is held.
    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (req) state_nxt = PENDING;
            PENDING: begin
                if (!req)                            state_nxt = UNLOCKED;
                else if (frame_seen && !frame_done) state_nxt = LOCKED;
            end
            LOCKED:   if (!req) state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    // Lock FSM state, request level, registered buf_lock and the lock-entry snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= UNLOCKED;
            lock_req <= 1'b0;
            buf_lock <= 1'b0;
            snap_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_req <= req;
            buf_lock <= (state == LOCKED);
            if (state == PENDING && state_nxt == LOCKED) snap_cnt <= frame_cnt;
        end
    end

    // Free-running frame counter; frame_seen gates the first grant after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt  <= '0;
            frame_seen <= 1'b0;
        end else if (frame_done) begin
            frame_cnt  <= frame_cnt + 1'b1;
            frame_seen <= 1'b1;
        end
    end

    // Frames arriving while locked are lost to the host; count them, clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_cnt    <= 8'h00;
            ovr_sticky <= 1'b0;
        end else if (clr) begin
            ovr_cnt    <= 8'h00;
            ovr_sticky <= 1'b0;
        end else if (state == LOCKED && frame_done) begin
            if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'h01;
            ovr_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sfft_readout_bridge.sv
// Bench for sfft_readout_bridge at default parameters with a synchronous BRAM model.
// Reads are scored: expected bytes queue at request time and are popped two edges later.
// Lock/overrun corner cases are driven as hand-written sequences.
module tb_sfft_readout_bridge;

    localparam int S = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write, read;
    logic [15:0] address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        frame_done;
    logic        buf_lock;
    logic [7:0]  buf_addr;
    logic [31:0] buf_data;

    logic [31:0] mem [256];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  exp;
    } vec_t;

    vec_t sb[$];
    vec_t t_rst[6];
    vec_t t_lock[6];
    vec_t t_buf[8];
    vec_t t_clr[6];

    int   n_cmp = 0;
    int   n_fail = 0;
    logic [1:0] rd_pipe = 2'b00;

    sfft_readout_bridge dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .frame_done(frame_done), .buf_lock(buf_lock), .buf_addr(buf_addr), .buf_data(buf_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) buf_data <= mem[buf_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: a read sampled at edge N is visible after edge N+2.
    always @(posedge clk) rd_pipe <= {rd_pipe[0], chipselect & read};

    always @(negedge clk) begin
        if (rd_pipe[1]) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check($sformatf("rd@%0d", e.addr), {24'h0, readdata}, {24'h0, e.exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_req(input logic [15:0] a, input logic [7:0] e);
        vec_t v;
        v.addr = a;
        v.exp  = e;
        sb.push_back(v);
        chipselect = 1'b1; read = 1'b1; address = a;
        step();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic wr_req(input logic [15:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic drain();
        repeat (3) step();
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic wait_lock(input string name);
        for (int i = 0; i < 4 && buf_lock !== 1'b1; i++) step();
        check(name, buf_lock, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        t_rst[0] = '{16'(S+4), 8'h00};  t_rst[1] = '{16'(S+5), 8'h00};
        t_rst[2] = '{16'(S),   8'h00};  t_rst[3] = '{16'(S+3), 8'h00};
        t_rst[4] = '{16'(S+6), 8'h00};  t_rst[5] = '{16'(0),   8'h00};

        t_lock[0] = '{16'(S),   8'h03}; t_lock[1] = '{16'(S+1), 8'h00};
        t_lock[2] = '{16'(S+2), 8'h00}; t_lock[3] = '{16'(S+3), 8'h00};
        t_lock[4] = '{16'(S+4), 8'h03}; t_lock[5] = '{16'(S+5), 8'h00};

        t_buf[0] = '{16'(20),  8'hD4};  t_buf[1] = '{16'(21),  8'hC3};
        t_buf[2] = '{16'(22),  8'hB2};  t_buf[3] = '{16'(23),  8'hA1};
        t_buf[4] = '{16'(S+6), 8'h00};  t_buf[5] = '{16'(S+100), 8'h00};
        t_buf[6] = '{16'(1020), 8'h44}; t_buf[7] = '{16'(1023), 8'h11};

        t_clr[0] = '{16'(S),   8'h00};  t_clr[1] = '{16'(S+1), 8'h00};
        t_clr[2] = '{16'(S+2), 8'h00};  t_clr[3] = '{16'(S+3), 8'h00};
        t_clr[4] = '{16'(S+4), 8'h00};  t_clr[5] = '{16'(S+5), 8'h00};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[5]   = 32'hA1B2C3D4;
        mem[255] = 32'h11223344;

        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; frame_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        check("rst_readdata", readdata, 8'h00);
        check("rst_buf_lock", buf_lock, 1'b0);
        check("rst_buf_addr", buf_addr, 8'h00);
        for (int i = 0; i < 6; i++) rd_req(t_rst[i].addr, t_rst[i].exp);
        drain();

        // Lock request with no frame yet: stays pending.
        wr_req(16'(S+4), 8'h01);
        repeat (100) step();
        check("pending_buf_lock", buf_lock, 1'b0);
        rd_req(16'(S+4), 8'h00);
        drain();

        // Three frames, then lock: snapshot 3.
        wr_req(16'(S+4), 8'h00);
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            step();
        end
        wr_req(16'(S+4), 8'h01);
        wait_lock("lock_grant");
        for (int i = 0; i < 6; i++) rd_req(t_lock[i].addr, t_lock[i].exp);
        drain();

        // 300 frames while locked: overrun saturates.
        for (int i = 0; i < 300; i++) pulse_frame();
        rd_req(16'(S+5), 8'hFF);
        rd_req(16'(S+4), 8'h07);
        drain();
        wr_req(16'(S+4), 8'h03);
        rd_req(16'(S+5), 8'h00);
        rd_req(16'(S+4), 8'h03);
        drain();
        check("lock_after_clear", buf_lock, 1'b1);

        // Buffer lanes, back-to-back, plus out-of-range addresses.
        for (int i = 0; i < 8; i++) rd_req(t_buf[i].addr, t_buf[i].exp);
        drain();
        step();
        check("readdata_hold", readdata, 8'h11);

        // Unlock: 303 frames counted so far.
        wr_req(16'(S+4), 8'h00);
        step();
        check("unlock_buf_lock", buf_lock, 1'b0);
        step();

        // frame_done on the would-be grant cycle: grant slips, snapshot includes it (304).
        wr_req(16'(S+4), 8'h01);
        pulse_frame();
        wait_lock("lock_grant_coincident");
        rd_req(16'(S),   8'h30);
        rd_req(16'(S+1), 8'h01);
        rd_req(16'(S+4), 8'h03);
        rd_req(16'(S+5), 8'h00);
        drain();

        // Write elsewhere is ignored; relock write does not reload snapshot.
        wr_req(16'(S+3), 8'h00);
        step();
        check("ignored_write", buf_lock, 1'b1);
        pulse_frame();
        wr_req(16'(S+4), 8'h01);
        rd_req(16'(S),   8'h30);
        rd_req(16'(S+5), 8'h01);
        rd_req(16'(S+4), 8'h07);
        drain();

        // Clear coinciding with a locked frame: clear wins.
        chipselect = 1'b1; write = 1'b1; address = 16'(S+4); writedata = 8'h03; frame_done = 1'b1;
        step();
        chipselect = 1'b0; write = 1'b0; frame_done = 1'b0;
        rd_req(16'(S+5), 8'h00);
        rd_req(16'(S+4), 8'h03);
        drain();

        // Asynchronous reset mid-lock.
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("async_rst_buf_lock", buf_lock, 1'b0);
        check("async_rst_readdata", readdata, 8'h00);
        #2 reset = 1'b0;
        step();
        for (int i = 0; i < 6; i++) rd_req(t_clr[i].addr, t_clr[i].exp);
        drain();

        // frame_seen cleared: a new lock waits for a fresh frame.
        wr_req(16'(S+4), 8'h01);
        repeat (10) step();
        check("post_rst_no_grant", buf_lock, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
